bcd_clock_counter: RTL and testbench
====================================

# bcd_clock_counter

Time-keeping core for the digital clock. It divides the board clock into a one-second tick and keeps hours, minutes and seconds as BCD digits. It presents four BCD digits on a 16-bit word that feeds the four-digit seven-segment display driver's `x` input directly. Manual minute/hour increment inputs allow the time to be set.

## Interface
- `TICK_COUNT`, default 100000000: clk cycles per second. Legal range ≥ 2.
- `clk` in 1: system clock. All logic is on the rising edge.
- `clr` in 1: reset, synchronous and active-high. It has priority over every other input.
- `run` in 1: 1 = time advances; 0 = prescaler and seconds frozen.
- `inc_min` in 1: single-cycle pulse (already debounced) that advances minutes by one.
- `inc_hr` in 1: single-cycle pulse (already debounced) that advances hours by one.
- `disp_sel` in 1: 0 = show MM:SS, 1 = show HH:MM.
- `x` out 16: display word of four BCD nibbles, MSB nibble = leftmost digit.
- `sec_tick` out 1: one-cycle pulse, high in the cycle the new seconds value is first visible.

## Operation
- Registers:
  - prescaler `pcnt`, width clog2(TICK_COUNT), range 0..TICK_COUNT-1.
  - BCD fields `s1`, `s10`, `m1`, `m10`, `h1`, `h10`, each 4 bits.
  - `sec_tick` register.
- Reset (`clr`=1 at an edge):
  - `pcnt`=0, all BCD fields=0, `sec_tick`=0, so `x`=16'h0000.
  - `clr` applied mid-count fully discards the partial second.
- Prescaler:
  - If `run`=1 and `pcnt`=TICK_COUNT-1: `pcnt`←0 and a tick event occurs at this edge.
  - Else if `run`=1: `pcnt`←`pcnt`+1.
  - If `run`=0: `pcnt` holds and no tick event occurs.
- `sec_tick`←1 on a tick-event edge, else ←0.
- Seconds on a tick event:
  - `s1` counts 0..9. On wrap, `s10` increments.
  - `s10` counts 0..5. 59→00 generates a minute carry.
- Minutes:
  - Advanced by the minute carry or by `inc_min`, wrapping 59→00.
  - A wrap caused by the carry generates an hour carry.
  - A wrap caused by `inc_min` does NOT carry into hours.
- Hours:
  - Advanced by the hour carry or by `inc_hr`.
  - 23→00 wrap, i.e. `h10`=2 and `h1`=3 → 00.
  - `h1` counts 0..9 while `h10`<2.
- Manual inputs:
  - Honoured regardless of `run`.
  - They never touch seconds or `pcnt`.
- Simultaneous events at one edge:
  - `inc_min` and a minute carry: minutes advance by exactly one. The manual path wins, the carry is dropped, and no hour carry is generated.
  - `inc_hr` and an hour carry: hours advance by exactly one.
  - `inc_min` and `inc_hr` together: both fields advance independently.
  - `clr` overrides all of the above.
- BCD fields never hold values above 9 (above 5 for tens-of-minutes/seconds, above 2 for `h10`).
- Output mux (combinational from registers):
  - `disp_sel`=0: `x`={`m10`,`m1`,`s10`,`s1`}.
  - `disp_sel`=1: `x`={`h10`,`h1`,`m10`,`m1`}.

## Timing
- Tick period is exactly TICK_COUNT cycles while `run`=1.
- First tick after reset arrives TICK_COUNT edges after the `clr` edge, with `run` held at 1.
- Field updates and `sec_tick` are registered on the same edge. `sec_tick`=1 in the cycle where `x` first shows the new seconds value.
- `inc_min`/`inc_hr` sampled high at edge N: new value visible in the cycle after edge N. One increment per cycle the input is high; a held input increments every cycle.
- `disp_sel` change: `x` reflects it in the same cycle (zero latency).
- Pausing (`run`=0) preserves `pcnt`. Resuming continues the partial second, so the interval from resume to the next tick = TICK_COUNT − `pcnt`.
- Carry ripple 23:59:59→00:00:00 completes in a single edge with no intermediate values visible.

## Test plan
1. Reset: TICK_COUNT=4, `clr`=1 for 2 cycles, then `run`=1 → `x`=0000 and `sec_tick`=0 until the 4th edge after `clr` falls. Then `sec_tick`=1 for one cycle and `x`=0001, with ticks every 4 cycles thereafter.
2. Second/minute rollover: count to MM:SS=00:59, one more tick → `x`=0100. With `disp_sel`=1 → `x`=0001 (HH:MM=00:01) in the same cycle.
3. Day wrap:
   - Setup: `inc_hr`×23, `inc_min`×59, then 59 ticks → HH:MM:SS 23:59:59.
   - Next tick → all fields 0. With `disp_sel`=1 → `x`=0000, and no intermediate value is seen.
4. Manual wrap and freeze:
   - At 05:59 with `run`=0, pulse `inc_min` → minutes 00, hours stay 05, seconds unchanged.
   - With `run`=0 held for 20 cycles → no `sec_tick`, and `pcnt` is preserved across resume.
5. Collision: at xx:14:59 with `pcnt`=TICK_COUNT-1, assert `inc_min` on the tick edge → time xx:15:00, not xx:16:00. Repeat at xx:59:59 → minutes 00 and hours unchanged.
6. Mid-operation reset: at 12:34:56 with `pcnt`=2, assert `clr` together with `inc_hr`=1 → next cycle all zero, `sec_tick`=0, and the next tick occurs a full TICK_COUNT cycles later.

Source files
------------

// File: rtl/bcd_clock_counter_if.sv
// Control and display signals between the time-keeping core and its user.
interface bcd_clock_counter_if;
  logic        run;
  logic        inc_min;
  logic        inc_hr;
  logic        disp_sel;
  logic [15:0] x;
  logic        sec_tick;

  modport master (
    output run, inc_min, inc_hr, disp_sel,
    input  x, sec_tick
  );

  modport slave (
    input  run, inc_min, inc_hr, disp_sel,
    output x, sec_tick
  );
endinterface

// File: rtl/bcd_clock_counter.sv
// BCD time-of-day counter: one-second prescaler, HH:MM:SS in BCD digits,
// manual minute/hour set inputs and a four-digit display word.
module bcd_clock_counter #(
  parameter int TICK_COUNT = 100000000
) (
  input logic                  clk,
  input logic                  clr,
  bcd_clock_counter_if.slave   bus
);

  localparam int              PW   = (TICK_COUNT > 2) ? $clog2(TICK_COUNT) : 1;
  localparam logic [PW-1:0]   LAST = PW'(TICK_COUNT - 1);

  logic [PW-1:0] r_pcnt;
  logic [3:0]    r_s1, r_s10, r_m1, r_m10, r_h1, r_h10;
  logic          r_sec_tick;

  logic          w_tick, w_min_carry, w_hr_carry, w_min_adv, w_hr_adv;
  logic [3:0]    w_s1, w_s10, w_m1, w_m10, w_h1, w_h10;

  // Next-state of the BCD fields; the manual minute pulse absorbs a
  // simultaneous seconds carry so minutes only move by one.
  always_comb begin
    w_s1        = r_s1;
    w_s10       = r_s10;
    w_m1        = r_m1;
    w_m10       = r_m10;
    w_h1        = r_h1;
    w_h10       = r_h10;
    w_min_carry = 1'b0;
    w_tick      = bus.run && (r_pcnt == LAST);

    if (w_tick) begin
      if (r_s1 == 4'd9) begin
        w_s1 = 4'd0;
        if (r_s10 == 4'd5) begin
          w_s10       = 4'd0;
          w_min_carry = 1'b1;
        end else begin
          w_s10 = r_s10 + 4'd1;
        end
      end else begin
        w_s1 = r_s1 + 4'd1;
      end
    end

    w_min_adv  = bus.inc_min | w_min_carry;
    w_hr_carry = w_min_carry & ~bus.inc_min & (r_m10 == 4'd5) & (r_m1 == 4'd9);

    if (w_min_adv) begin
      if (r_m1 == 4'd9) begin
        w_m1  = 4'd0;
        w_m10 = (r_m10 == 4'd5) ? 4'd0 : r_m10 + 4'd1;
      end else begin
        w_m1 = r_m1 + 4'd1;
      end
    end

    w_hr_adv = bus.inc_hr | w_hr_carry;

    if (w_hr_adv) begin
      if (r_h10 == 4'd2 && r_h1 == 4'd3) begin
        w_h1  = 4'd0;
        w_h10 = 4'd0;
      end else if (r_h1 == 4'd9) begin
        w_h1  = 4'd0;
        w_h10 = r_h10 + 4'd1;
      end else begin
        w_h1 = r_h1 + 4'd1;
      end
    end
  end

  // Register prescaler, time fields and tick strobe; clr discards everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_pcnt     <= '0;
      r_s1       <= 4'd0;
      r_s10      <= 4'd0;
      r_m1       <= 4'd0;
      r_m10      <= 4'd0;
      r_h1       <= 4'd0;
      r_h10      <= 4'd0;
      r_sec_tick <= 1'b0;
    end else begin
      if (bus.run) begin
        r_pcnt <= (r_pcnt == LAST) ? '0 : r_pcnt + PW'(1);
      end
      r_s1       <= w_s1;
      r_s10      <= w_s10;
      r_m1       <= w_m1;
      r_m10      <= w_m10;
      r_h1       <= w_h1;
      r_h10      <= w_h10;
      r_sec_tick <= w_tick;
    end
  end

  assign bus.x        = bus.disp_sel ? {r_h10, r_h1, r_m10, r_m1}
                                     : {r_m10, r_m1, r_s10, r_s1};
  assign bus.sec_tick = r_sec_tick;

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Self-checking bench for bcd_clock_counter with a time-of-day reference model.
module tb_bcd_clock_counter;

  localparam int T = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state: plain integers for hours/minutes/seconds
  int   m_h = 0, m_m = 0, m_s = 0, m_p = 0;
  bit   m_tick = 1'b0;

  bcd_clock_counter_if bus ();

  bcd_clock_counter #(.TICK_COUNT(T)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic [15:0] exp_x(logic sel);
    return sel ? {bcd(m_h), bcd(m_m)} : {bcd(m_m), bcd(m_s)};
  endfunction

  task automatic model_step();
    bit carry_m, carry_h;
    carry_m = 1'b0;
    carry_h = 1'b0;
    if (clr) begin
      m_h = 0; m_m = 0; m_s = 0; m_p = 0; m_tick = 1'b0;
      return;
    end
    m_tick = bus.run && (m_p == T - 1);
    if (bus.run) m_p = (m_p + 1) % T;
    if (m_tick) begin
      m_s = m_s + 1;
      if (m_s == 60) begin m_s = 0; carry_m = 1'b1; end
    end
    if (bus.inc_min) m_m = (m_m + 1) % 60;
    else if (carry_m) begin
      m_m = m_m + 1;
      if (m_m == 60) begin m_m = 0; carry_h = 1'b1; end
    end
    if (bus.inc_hr || carry_h) m_h = (m_h + 1) % 24;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic setup(int h, int m, int s, int p);
    clr = 1'b1; bus.run = 1'b0; bus.inc_min = 1'b0; bus.inc_hr = 1'b0;
    cycle();
    clr = 1'b0;
    for (int i = 0; i < h; i++) begin bus.inc_hr = 1'b1; cycle(); end
    bus.inc_hr = 1'b0;
    for (int i = 0; i < m; i++) begin bus.inc_min = 1'b1; cycle(); end
    bus.inc_min = 1'b0;
    bus.run = 1'b1;
    for (int i = 0; i < s * T + p; i++) cycle();
    bus.run = 1'b0;
  endtask

  task automatic test_reset();
    bus.run = 1'b0; bus.inc_min = 1'b0; bus.inc_hr = 1'b0; bus.disp_sel = 1'b0;
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      vectors++;
      if (bus.x !== 16'h0000 || bus.sec_tick !== 1'b0) begin
        miscompares++;
        $display("FAIL reset x=%h tick=%b expected x=0000 tick=0", bus.x, bus.sec_tick);
      end
    end
    clr = 1'b0; bus.run = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      vectors++;
      if (bus.x !== ((i == 4) ? 16'h0001 : 16'h0000) || bus.sec_tick !== (i == 4)) begin
        miscompares++;
        $display("FAIL first_tick edge %0d x=%h tick=%b expected x=%h tick=%b",
                 i, bus.x, bus.sec_tick, (i == 4) ? 16'h0001 : 16'h0000, (i == 4));
      end
    end
    for (int i = 0; i < 8; i++) begin
      cycle();
      vectors++;
      if (bus.x !== exp_x(bus.disp_sel) || bus.sec_tick !== m_tick) begin
        miscompares++;
        $display("FAIL tick_period x=%h tick=%b expected x=%h tick=%b",
                 bus.x, bus.sec_tick, exp_x(bus.disp_sel), m_tick);
      end
    end
  endtask

  task automatic test_rollover();
    setup(0, 0, 0, 0);
    bus.run = 1'b1; bus.disp_sel = 1'b0;
    for (int i = 0; i < 60 * T; i++) begin
      cycle();
      vectors++;
      if (bus.x !== exp_x(1'b0) || bus.sec_tick !== m_tick) begin
        miscompares++;
        $display("FAIL rollover x=%h tick=%b expected x=%h tick=%b",
                 bus.x, bus.sec_tick, exp_x(1'b0), m_tick);
      end
    end
    vectors++;
    if (bus.x !== 16'h0100 || bus.sec_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL rollover_0100 x=%h tick=%b expected x=0100 tick=1", bus.x, bus.sec_tick);
    end
    bus.disp_sel = 1'b1;
    #1;
    vectors++;
    if (bus.x !== 16'h0001) begin
      miscompares++;
      $display("FAIL disp_sel_zero_latency x=%h expected x=0001", bus.x);
    end
    bus.disp_sel = 1'b0;
  endtask

  task automatic test_day_wrap();
    setup(23, 59, 59, 0);
    bus.disp_sel = 1'b1;
    #1;
    vectors++;
    if (bus.x !== 16'h2359) begin
      miscompares++;
      $display("FAIL day_setup x=%h expected x=2359", bus.x);
    end
    bus.run = 1'b1;
    for (int i = 1; i <= T; i++) begin
      cycle();
      vectors++;
      if (bus.x !== ((i == T) ? 16'h0000 : 16'h2359) || bus.sec_tick !== (i == T)) begin
        miscompares++;
        $display("FAIL day_wrap edge %0d x=%h tick=%b expected x=%h tick=%b",
                 i, bus.x, bus.sec_tick, (i == T) ? 16'h0000 : 16'h2359, (i == T));
      end
    end
    bus.disp_sel = 1'b0;
    #1;
    vectors++;
    if (bus.x !== 16'h0000) begin
      miscompares++;
      $display("FAIL day_wrap_mmss x=%h expected x=0000", bus.x);
    end
  endtask

  task automatic test_manual_wrap_freeze();
    int waited;
    setup(5, 59, 10, 2);
    bus.inc_min = 1'b1;
    cycle();
    bus.inc_min = 1'b0;
    bus.disp_sel = 1'b0;
    #1;
    vectors++;
    if (bus.x !== 16'h0010) begin
      miscompares++;
      $display("FAIL manual_wrap_mmss x=%h expected x=0010", bus.x);
    end
    bus.disp_sel = 1'b1;
    #1;
    vectors++;
    if (bus.x !== 16'h0500) begin
      miscompares++;
      $display("FAIL manual_wrap_hhmm x=%h expected x=0500", bus.x);
    end
    bus.disp_sel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      vectors++;
      if (bus.sec_tick !== 1'b0 || bus.x !== 16'h0010) begin
        miscompares++;
        $display("FAIL freeze x=%h tick=%b expected x=0010 tick=0", bus.x, bus.sec_tick);
      end
    end
    bus.run = 1'b1;
    waited = 0;
    do begin
      cycle();
      waited++;
    end while (bus.sec_tick !== 1'b1 && waited < 3 * T);
    vectors++;
    if (waited !== T - 2 || bus.x !== 16'h0011) begin
      miscompares++;
      $display("FAIL resume cycles=%0d x=%h expected cycles=%0d x=0011", waited, bus.x, T - 2);
    end
  endtask

  task automatic test_collision();
    setup(7, 14, 59, T - 1);
    bus.run = 1'b1; bus.inc_min = 1'b1; bus.disp_sel = 1'b0;
    cycle();
    bus.inc_min = 1'b0;
    vectors++;
    if (bus.x !== 16'h1500 || bus.sec_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_14_59 x=%h tick=%b expected x=1500 tick=1", bus.x, bus.sec_tick);
    end
    setup(3, 59, 59, T - 1);
    bus.run = 1'b1; bus.inc_min = 1'b1;
    cycle();
    bus.inc_min = 1'b0;
    vectors++;
    if (bus.x !== 16'h0000) begin
      miscompares++;
      $display("FAIL collision_59_59 x=%h expected x=0000", bus.x);
    end
    bus.disp_sel = 1'b1;
    #1;
    vectors++;
    if (bus.x !== 16'h0300) begin
      miscompares++;
      $display("FAIL collision_hours x=%h expected x=0300", bus.x);
    end
    bus.disp_sel = 1'b0;
  endtask

  task automatic test_mid_reset();
    int waited;
    setup(12, 34, 56, 2);
    bus.disp_sel = 1'b1;
    #1;
    vectors++;
    if (bus.x !== 16'h1234) begin
      miscompares++;
      $display("FAIL mid_setup x=%h expected x=1234", bus.x);
    end
    bus.disp_sel = 1'b0;
    clr = 1'b1; bus.inc_hr = 1'b1; bus.run = 1'b1;
    cycle();
    clr = 1'b0; bus.inc_hr = 1'b0;
    vectors++;
    if (bus.x !== 16'h0000 || bus.sec_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset x=%h tick=%b expected x=0000 tick=0", bus.x, bus.sec_tick);
    end
    waited = 0;
    do begin
      cycle();
      waited++;
    end while (bus.sec_tick !== 1'b1 && waited < 3 * T);
    vectors++;
    if (waited !== T || bus.x !== 16'h0001) begin
      miscompares++;
      $display("FAIL mid_reset_tick cycles=%0d x=%h expected cycles=%0d x=0001", waited, bus.x, T);
    end
  endtask

  task automatic test_back_to_back();
    setup(22, 0, 0, 0);
    bus.inc_min = 1'b1; bus.inc_hr = 1'b1; bus.disp_sel = 1'b1;
    for (int i = 0; i < 70; i++) begin
      cycle();
      vectors++;
      if (bus.x !== exp_x(1'b1)) begin
        miscompares++;
        $display("FAIL held_inc x=%h expected x=%h", bus.x, exp_x(1'b1));
      end
    end
    bus.inc_min = 1'b0; bus.inc_hr = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      clr          = ($urandom_range(0, 399) == 0);
      bus.run      = ($urandom_range(0, 9) != 0);
      bus.inc_min  = ($urandom_range(0, 5) == 0);
      bus.inc_hr   = ($urandom_range(0, 19) == 0);
      bus.disp_sel = $urandom_range(0, 1);
      cycle();
      vectors++;
      if (bus.x !== exp_x(bus.disp_sel) || bus.sec_tick !== m_tick) begin
        miscompares++;
        $display("FAIL random cycle %0d x=%h tick=%b expected x=%h tick=%b",
                 i, bus.x, bus.sec_tick, exp_x(bus.disp_sel), m_tick);
      end
    end
    clr = 1'b0; bus.inc_min = 1'b0; bus.inc_hr = 1'b0;
  endtask

  initial begin
    bus.run = 1'b0; bus.inc_min = 1'b0; bus.inc_hr = 1'b0; bus.disp_sel = 1'b0;
    test_reset();
    test_rollover();
    test_day_wrap();
    test_manual_wrap_freeze();
    test_collision();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
